// File: rtl/ef_pwm_mc_if.sv
// rtl/ef_pwm_mc_if.sv - configuration and output bundle of the multi-channel PWM core
interface ef_pwm_mc_if #(
    parameter int W   = 32,
    parameter int N   = 4,
    parameter int DTW = 8
);
    logic             en;
    logic [N-1:0]     en_ch;
    logic [3:0]       clkdiv;
    logic             cntr_mode;
    logic [W-1:0]     load;
    logic [N*W-1:0]   cmp;
    logic [N*8-1:0]   act;
    logic [N-1:0]     inv;
    logic [DTW-1:0]   dt;
    logic [W-1:0]     cntr;
    logic             dir;
    logic             prd;
    logic [N-1:0]     pwm_h;
    logic [N-1:0]     pwm_l;

    modport master (
        output en, en_ch, clkdiv, cntr_mode, load, cmp, act, inv, dt,
        input  cntr, dir, prd, pwm_h, pwm_l
    );

    modport slave (
        input  en, en_ch, clkdiv, cntr_mode, load, cmp, act, inv, dt,
        output cntr, dir, prd, pwm_h, pwm_l
    );
endinterface

// File: rtl/ef_pwm_mc.sv
// rtl/ef_pwm_mc.sv - shared up/up-down timebase driving N PWM channels with dead time
module ef_pwm_mc #(
    parameter int W   = 32,
    parameter int N   = 4,
    parameter int DTW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    ef_pwm_mc_if.slave  bus
);
    logic [3:0]              pre_q, pre_d;
    logic [W-1:0]            cntr_q, cntr_d;
    logic                    dir_q, dir_d;
    logic                    prd_q, prd_d;
    logic [N-1:0]            g_q, g_d;
    logic                    mode_q, mode_d;
    logic [W-1:0]            load_q, load_d;
    logic [N*W-1:0]          cmp_q, cmp_d;
    logic [N*8-1:0]          act_q, act_d;
    logic [N-1:0]            a_q, a_d;
    logic [N-1:0]            ok_q, ok_d;
    logic [N-1:0]            pwm_h_q, pwm_h_d;
    logic [N-1:0]            pwm_l_q, pwm_l_d;
    logic [N-1:0][DTW-1:0]   dtc_q, dtc_d;
    logic                    tick, boundary;
    logic [W-1:0]            ci;
    logic [7:0]              ai;
    logic [1:0]              sel;
    logic                    ev_top, ev_cd, ev_cu, ev_z, ok, a;

    assign tick = bus.en && (pre_q == bus.clkdiv);

    // load<=1 in up/down never reaches (dir=1, cntr=1), so its period closes at top
    assign boundary = tick && (mode_q ? ((dir_q && cntr_q == W'(1)) ||
                                         (load_q <= W'(1) && cntr_q == load_q))
                                      : (cntr_q == load_q));

    always_comb begin
        pre_d  = (!bus.en || tick) ? 4'd0 : pre_q + 4'd1;
        cntr_d = cntr_q;
        dir_d  = dir_q;
        if (!bus.en) begin
            cntr_d = '0;
            dir_d  = 1'b0;
        end else if (tick) begin
            if (load_q == '0) begin
                cntr_d = '0;
                dir_d  = 1'b0;
            end else if (!mode_q) begin
                cntr_d = (cntr_q >= load_q) ? '0 : cntr_q + W'(1);
                dir_d  = 1'b0;
            end else if (!dir_q) begin
                if (cntr_q >= load_q) begin
                    cntr_d = load_q - W'(1);
                    dir_d  = 1'b1;
                end else begin
                    cntr_d = cntr_q + W'(1);
                end
            end else if (cntr_q == '0) begin
                cntr_d = W'(1);
                dir_d  = 1'b0;
            end else begin
                cntr_d = cntr_q - W'(1);
            end
        end
    end

    always_comb begin
        mode_d = mode_q;
        load_d = load_q;
        cmp_d  = cmp_q;
        act_d  = act_q;
        prd_d  = boundary;
        if (!bus.en || boundary) begin
            mode_d = bus.cntr_mode;
            load_d = bus.load;
            cmp_d  = bus.cmp;
            act_d  = bus.act;
        end
    end

    // highest-priority event carrying a real action wins: top > cmp-down > cmp-up > zero
    always_comb begin
        g_d    = g_q;
        ci     = '0;
        ai     = '0;
        sel    = 2'b00;
        ev_top = 1'b0;
        ev_cd  = 1'b0;
        ev_cu  = 1'b0;
        ev_z   = 1'b0;
        for (int i = 0; i < N; i++) begin
            ci     = cmp_q[i*W +: W];
            ai     = act_q[i*8 +: 8];
            ev_top = (cntr_q == load_q);
            ev_cd  = mode_q && dir_q && (cntr_q == ci) && (ci <= load_q);
            ev_cu  = !dir_q && (cntr_q == ci) && (ci <= load_q);
            ev_z   = (cntr_q == '0);
            sel    = 2'b00;
            if (ev_z   && ai[1:0] != 2'b00) sel = ai[1:0];
            if (ev_cu  && ai[3:2] != 2'b00) sel = ai[3:2];
            if (ev_cd  && ai[5:4] != 2'b00) sel = ai[5:4];
            if (ev_top && ai[7:6] != 2'b00) sel = ai[7:6];
            if (!bus.en) begin
                g_d[i] = 1'b0;
            end else if (tick) begin
                case (sel)
                    2'b01:   g_d[i] = 1'b0;
                    2'b10:   g_d[i] = 1'b1;
                    2'b11:   g_d[i] = ~g_q[i];
                    default: g_d[i] = g_q[i];
                endcase
            end
        end
    end

    // a change of level or a gating edge restarts the dead time with both sides low
    always_comb begin
        a_d     = a_q;
        ok_d    = ok_q;
        dtc_d   = dtc_q;
        pwm_h_d = pwm_h_q;
        pwm_l_d = pwm_l_q;
        ok      = 1'b0;
        a       = 1'b0;
        for (int i = 0; i < N; i++) begin
            ok    = bus.en && bus.en_ch[i];
            a     = g_q[i] ^ bus.inv[i];
            a_d[i]  = a;
            ok_d[i] = ok;
            if (!ok || !ok_q[i] || (a != a_q[i])) begin
                dtc_d[i]   = bus.dt;
                pwm_h_d[i] = ok && (bus.dt == '0) && a;
                pwm_l_d[i] = ok && (bus.dt == '0) && !a;
            end else if (dtc_q[i] != '0) begin
                dtc_d[i]   = dtc_q[i] - DTW'(1);
                pwm_h_d[i] = (dtc_q[i] == DTW'(1)) && a;
                pwm_l_d[i] = (dtc_q[i] == DTW'(1)) && !a;
            end else begin
                pwm_h_d[i] = a;
                pwm_l_d[i] = !a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            cntr_q  <= '0;
            dir_q   <= 1'b0;
            prd_q   <= 1'b0;
            g_q     <= '0;
            mode_q  <= 1'b0;
            load_q  <= '0;
            cmp_q   <= '0;
            act_q   <= '0;
            a_q     <= '0;
            ok_q    <= '0;
            pwm_h_q <= '0;
            pwm_l_q <= '0;
            dtc_q   <= '0;
        end else begin
            pre_q   <= pre_d;
            cntr_q  <= cntr_d;
            dir_q   <= dir_d;
            prd_q   <= prd_d;
            g_q     <= g_d;
            mode_q  <= mode_d;
            load_q  <= load_d;
            cmp_q   <= cmp_d;
            act_q   <= act_d;
            a_q     <= a_d;
            ok_q    <= ok_d;
            pwm_h_q <= pwm_h_d;
            pwm_l_q <= pwm_l_d;
            dtc_q   <= dtc_d;
        end
    end

    assign bus.cntr  = cntr_q;
    assign bus.dir   = dir_q;
    assign bus.prd   = prd_q;
    assign bus.pwm_h = pwm_h_q;
    assign bus.pwm_l = pwm_l_q;
endmodule

// File: tb/tb_ef_pwm_mc.sv
// tb/tb_ef_pwm_mc.sv - randomized bench for ef_pwm_mc against a period-position model
module tb_ef_pwm_mc;
    localparam int W   = 32;
    localparam int N   = 4;
    localparam int DTW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ef_pwm_mc_if #(.W(W), .N(N), .DTW(DTW)) bus ();
    ef_pwm_mc #(.W(W), .N(N), .DTW(DTW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // model: position k inside the current period plus the period's latched settings
    int          pre = 0, k = 0, m_load = 0, m_mode = 0;
    bit          dir0 = 1'b0;
    logic [N-1:0] g = '0, a_prev = '0, ok_prev = '0;
    int          m_cmp [N];
    logic [7:0]  m_act [N];
    int          run [N];
    int          e_cntr = 0;
    bit          e_dir = 1'b0, e_prd = 1'b0;
    logic [N-1:0] e_h = '0, e_l = '0;

    function automatic int cntr_of(int kk);
        return (m_mode != 0 && kk > m_load) ? 2 * m_load - kk : kk;
    endfunction

    function automatic bit dir_of(int kk);
        return (kk == 0) ? dir0 : (m_mode != 0 && kk > m_load);
    endfunction

    function automatic int plen();
        if (m_mode != 0) return (m_load == 0) ? 1 : 2 * m_load;
        return m_load + 1;
    endfunction

    task automatic latch_cfg();
        m_load = int'(bus.load);
        m_mode = int'(bus.cntr_mode);
        for (int i = 0; i < N; i++) begin
            m_cmp[i] = int'(bus.cmp[i*W +: W]);
            m_act[i] = bus.act[i*8 +: 8];
        end
    endtask

    task automatic model_reset();
        pre = 0; k = 0; dir0 = 1'b0; g = '0; a_prev = '0; ok_prev = '0;
        m_load = 0; m_mode = 0;
        for (int i = 0; i < N; i++) begin
            m_cmp[i] = 0; m_act[i] = '0; run[i] = 0;
        end
        e_cntr = 0; e_dir = 1'b0; e_prd = 1'b0; e_h = '0; e_l = '0;
    endtask

    task automatic model_step();
        bit tick;
        int c;
        bit d;
        for (int i = 0; i < N; i++) begin
            bit ok, a;
            ok = bus.en && bus.en_ch[i];
            a  = g[i] ^ bus.inv[i];
            if (!ok || !ok_prev[i] || a != a_prev[i]) run[i] = 0;
            else if (run[i] < 1000) run[i]++;
            e_h[i] = ok && (run[i] >= int'(bus.dt)) && a;
            e_l[i] = ok && (run[i] >= int'(bus.dt)) && !a;
            a_prev[i]  = a;
            ok_prev[i] = ok;
        end
        e_prd = 1'b0;
        if (!bus.en) begin
            pre = 0; k = 0; dir0 = 1'b0; g = '0;
            latch_cfg();
        end else begin
            tick = (pre == int'(bus.clkdiv));
            pre  = tick ? 0 : pre + 1;
            if (tick) begin
                c = cntr_of(k);
                d = dir_of(k);
                for (int i = 0; i < N; i++) begin
                    bit       fired [4];
                    logic [1:0] code [4];
                    fired[0] = (c == m_load);                                   code[0] = m_act[i][7:6];
                    fired[1] = (m_mode != 0) && d && c == m_cmp[i] && m_cmp[i] <= m_load; code[1] = m_act[i][5:4];
                    fired[2] = !d && c == m_cmp[i] && m_cmp[i] <= m_load;        code[2] = m_act[i][3:2];
                    fired[3] = (c == 0);                                        code[3] = m_act[i][1:0];
                    for (int p = 0; p < 4; p++) begin
                        if (fired[p] && code[p] != 2'b00) begin
                            g[i] = (code[p] == 2'b01) ? 1'b0 : (code[p] == 2'b10) ? 1'b1 : ~g[i];
                            break;
                        end
                    end
                end
                if (k == plen() - 1) begin
                    dir0  = (m_mode != 0) && (m_load > 0);
                    k     = 0;
                    e_prd = 1'b1;
                    latch_cfg();
                end else begin
                    k++;
                end
            end
        end
        e_cntr = cntr_of(k);
        e_dir  = dir_of(k);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        n_cmp++;
        if ({bus.cntr, bus.dir, bus.prd, bus.pwm_h, bus.pwm_l} !==
            {W'(e_cntr), e_dir, e_prd, e_h, e_l}) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL model t=%0t cntr=%0d/%0d dir=%b/%b prd=%b/%b pwm_h=%b/%b pwm_l=%b/%b (got/expected)",
                         $time, bus.cntr, e_cntr, bus.dir, e_dir, bus.prd, e_prd,
                         bus.pwm_h, e_h, bus.pwm_l, e_l);
        end
    end

    task automatic check(input string nm, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic set_ch0(input int c0, input logic [7:0] a0);
        bus.cmp = '0;
        bus.act = '0;
        bus.cmp[0 +: W] = W'(c0);
        bus.act[0 +: 8] = a0;
    endtask

    task automatic random_cfg();
        bus.cntr_mode = 1'($urandom_range(0, 1));
        bus.load      = W'($urandom_range(0, 12));
        for (int i = 0; i < N; i++) bus.cmp[i*W +: W] = W'($urandom_range(0, 14));
        bus.act = ($urandom);
    endtask

    initial begin
        int ud_exp [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
        int hcnt, p0, p1, first;
        bus.en = 1'b0; bus.en_ch = '1; bus.clkdiv = '0; bus.cntr_mode = 1'b0;
        bus.load = '0; bus.cmp = '0; bus.act = '0; bus.inv = '0; bus.dt = '0;
        repeat (3) @(negedge clk);
        check("reset_cntr", bus.cntr, 0);
        check("reset_pwm", {bus.pwm_h, bus.pwm_l}, 0);
        check("reset_prd_dir", {bus.prd, bus.dir}, 0);
        rst_n = 1'b1;

        // up/down centred pulse
        bus.cntr_mode = 1'b1; bus.load = W'(4); set_ch0(2, 8'h18);
        @(negedge clk); bus.en = 1'b1;
        hcnt = 0;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk); #2;
            if (j < 8) check($sformatf("ud_cntr_%0d", j), bus.cntr, ud_exp[j]);
            else hcnt += int'(bus.pwm_h[0]);
        end
        check("ud_high_clk", hcnt, 4);

        // up mode, prd spacing
        @(negedge clk); bus.en = 1'b0;
        bus.cntr_mode = 1'b0; bus.load = W'(9); set_ch0(4, 8'h06);
        @(negedge clk); bus.en = 1'b1;
        p0 = -1; p1 = -1;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk); #2;
            if (bus.prd) begin
                if (p0 < 0) p0 = j;
                else if (p1 < 0) p1 = j;
            end
        end
        check("prd_spacing", p1 - p0, 10);

        // dead time then channel gating
        @(negedge clk); bus.en = 1'b0; bus.dt = DTW'(3);
        @(negedge clk); bus.en = 1'b1;
        repeat (40) @(negedge clk);
        bus.en_ch[1] = 1'b0;
        @(posedge clk); #2;
        check("gate_off", {bus.pwm_h[1], bus.pwm_l[1]}, 0);
        @(negedge clk); bus.en_ch[1] = 1'b1;
        first = -1;
        for (int j = 0; j < 20 && first < 0; j++) begin
            @(posedge clk); #2;
            if (bus.pwm_l[1]) first = j;
        end
        check("gate_restore_clk", first, 3);

        // asynchronous reset mid-period
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm", {bus.pwm_h, bus.pwm_l}, 0);
        check("async_rst_cntr", bus.cntr, 0);
        @(negedge clk); rst_n = 1'b1;

        // prescaler and cmp-up over zero priority
        @(negedge clk); bus.en = 1'b0; bus.clkdiv = 4'd2; bus.dt = '0;
        bus.cntr_mode = 1'b0; bus.load = W'(9); set_ch0(0, 8'h06);
        @(negedge clk); bus.en = 1'b1;
        hcnt = 0;
        for (int j = 0; j < 60; j++) begin
            @(posedge clk); #2;
            if (j == 4) check("pre_cntr_j4", bus.cntr, 1);
            if (j == 5) check("pre_cntr_j5", bus.cntr, 2);
            hcnt += int'(bus.pwm_h[0]);
        end
        check("priority_no_high", hcnt, 0);

        // randomized segments
        for (int s = 0; s < 30; s++) begin
            int len;
            @(negedge clk);
            bus.en = 1'b0;
            bus.clkdiv = 4'($urandom_range(0, 3));
            bus.dt = DTW'($urandom_range(0, 4));
            bus.inv = N'($urandom);
            bus.en_ch = N'($urandom) | N'(1);
            random_cfg();
            repeat ($urandom_range(1, 3)) @(negedge clk);
            bus.en = 1'b1;
            len = int'($urandom_range(80, 250));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 19) == 0) random_cfg();
                if ($urandom_range(0, 29) == 0) bus.inv = N'($urandom);
                if ($urandom_range(0, 39) == 0) bus.en_ch = N'($urandom);
                if ($urandom_range(0, 499) == 0) begin
                    #2 rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
